// File: rtl/mr_sto_pkg.sv
// Shared types for the relay-CPU store sequencer: FSM state encoding,
// pending-phase bit indices and the default handshake timeout.
package mr_sto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ALU  = 3'd1,
    ST_REG  = 3'd2,
    ST_RAM  = 3'd3,
    ST_IO   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int PH_ALU = 0;
  localparam int PH_REG = 1;
  localparam int PH_RAM = 2;
  localparam int PH_IO  = 3;

  localparam int TIMEOUT_DEF = 15;

  // Lowest-order pending phase wins; an empty mask means the sequence is done.
  function automatic state_t first_phase(input logic [3:0] m);
    state_t s;
    if (m[PH_ALU])      s = ST_ALU;
    else if (m[PH_REG]) s = ST_REG;
    else if (m[PH_RAM]) s = ST_RAM;
    else if (m[PH_IO])  s = ST_IO;
    else                s = ST_FIN;
    return s;
  endfunction

endpackage

// File: rtl/mr_ack_timer.sv
// Wait counter for the RAM/IO handshakes: cleared on entry to a wait state,
// counts waiting cycles and flags expiry on the TIMEOUT-th waiting cycle.
module mr_ack_timer
  import mr_sto_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the number of waiting cycles already completed.
  assign expired = run && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mr_store_sequencer.sv
// Write-back phase sequencer: runs the captured store strobes as ordered
// write phases. Define MR_STO_TIMEOUT_EN to bound the RAM/IO ack waits.
module mr_store_sequencer
  import mr_sto_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EXEC,
  input  logic          STO_ALU,
  input  logic          STO_REG,
  input  logic          STO_RAM,
  input  logic          STO_IO,
  input  logic [15:0]   DST,
  input  logic [DW-1:0] ADDR,
  input  logic [DW-1:0] DATA,
  output logic [DW-1:0] WDATA,
  output logic [DW-1:0] WADDR,
  output logic          ALU_LD,
  output logic          REG_WE,
  output logic [2:0]    REG_SEL,
  output logic          RAM_WE,
  input  logic          RAM_ACK,
  output logic          IO_WR,
  input  logic          IO_ACK,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [2:0]    dbg_state
);

  state_t     state, state_nx;
  logic [3:0] mask, mask_nx;
  logic       accept;
  logic       tmo;

  logic [12:0] unused_dst;
  assign unused_dst = DST[15:3];
  assign dbg_state  = state;

  // Handshake: RAM_WE/IO_WR is a request held high, with WADDR/WDATA stable,
  // until the matching ACK is sampled high on a rising edge; that edge
  // completes the write and the request is low in the following cycle.
  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    accept   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (EXEC) begin
          accept   = 1'b1;
          mask_nx  = {STO_IO, STO_RAM, STO_REG, STO_ALU};
          state_nx = first_phase(mask_nx);
        end
      end
      ST_ALU: begin
        mask_nx[PH_ALU] = 1'b0;
        state_nx        = first_phase(mask_nx);
      end
      ST_REG: begin
        mask_nx[PH_REG] = 1'b0;
        state_nx        = first_phase(mask_nx);
      end
      ST_RAM: begin
        if (RAM_ACK || tmo) begin
          mask_nx[PH_RAM] = 1'b0;
          state_nx        = first_phase(mask_nx);
        end
      end
      ST_IO: begin
        if (IO_ACK || tmo) begin
          mask_nx[PH_IO] = 1'b0;
          state_nx       = first_phase(mask_nx);
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered
  // and line up with that state's cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      mask    <= '0;
      WDATA   <= '0;
      WADDR   <= '0;
      REG_SEL <= '0;
      ALU_LD  <= 1'b0;
      REG_WE  <= 1'b0;
      RAM_WE  <= 1'b0;
      IO_WR   <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state <= state_nx;
      mask  <= mask_nx;
      if (accept) begin
        WDATA   <= DATA;
        WADDR   <= ADDR;
        REG_SEL <= DST[2:0];
      end
      ALU_LD <= (state_nx == ST_ALU);
      REG_WE <= (state_nx == ST_REG);
      RAM_WE <= (state_nx == ST_RAM);
      IO_WR  <= (state_nx == ST_IO);
      DONE   <= (state_nx == ST_FIN);
      BUSY   <= (state_nx != ST_IDLE);
    end
  end

`ifdef MR_STO_TIMEOUT_EN
  logic timer_clr;
  logic timer_run;
  logic err_q;

  assign timer_run = (state == ST_RAM) || (state == ST_IO);
  assign timer_clr = ((state_nx == ST_RAM) || (state_nx == ST_IO)) && (state_nx != state);

  mr_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk     (CLK),
    .rst     (RST),
    .clr     (timer_clr),
    .run     (timer_run),
    .expired (tmo)
  );

  // An ack in the expiry cycle still counts as a clean completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (tmo && (((state == ST_RAM) && !RAM_ACK) ||
                         ((state == ST_IO) && !IO_ACK))) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(TIMEOUT);
  assign tmo        = 1'b0;
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_mr_store_sequencer.sv
// Directed bench for mr_store_sequencer: expected busy-cycle output vectors
// are queued by the stimulus and popped by an independent monitor.
module tb_mr_store_sequencer;

  localparam int DW = 16;
  localparam int VW = 42;

  localparam logic [4:0] V_ALU  = 5'b10000;
  localparam logic [4:0] V_REG  = 5'b01000;
  localparam logic [4:0] V_RAM  = 5'b00100;
  localparam logic [4:0] V_IO   = 5'b00010;
  localparam logic [4:0] V_DONE = 5'b00001;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EXEC = 1'b0;
  logic          STO_ALU = 1'b0, STO_REG = 1'b0, STO_RAM = 1'b0, STO_IO = 1'b0;
  logic [15:0]   DST = '0;
  logic [DW-1:0] ADDR = '0, DATA = '0;
  logic          RAM_ACK = 1'b0, IO_ACK = 1'b0;
  logic [DW-1:0] WDATA, WADDR;
  logic          ALU_LD, REG_WE, RAM_WE, IO_WR, BUSY, DONE, ERR;
  logic [2:0]    REG_SEL;
  logic [2:0]    dbg_state;

  logic [VW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  logic [2:0]    cur_sel  = '0;
  logic [15:0]   cur_addr = '0;
  logic [15:0]   cur_data = '0;

  mr_store_sequencer #(.DW(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .EXEC(EXEC),
    .STO_ALU(STO_ALU), .STO_REG(STO_REG), .STO_RAM(STO_RAM), .STO_IO(STO_IO),
    .DST(DST), .ADDR(ADDR), .DATA(DATA),
    .WDATA(WDATA), .WADDR(WADDR), .ALU_LD(ALU_LD), .REG_WE(REG_WE),
    .REG_SEL(REG_SEL), .RAM_WE(RAM_WE), .RAM_ACK(RAM_ACK),
    .IO_WR(IO_WR), .IO_ACK(IO_ACK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1);
  end

  // Scoreboard helpers
  function automatic logic [VW-1:0] vec(input logic [4:0] strb, input logic err);
    return {strb, 1'b1, err, cur_sel, cur_addr, cur_data};
  endfunction

  task automatic set_cur(input logic [2:0] sel, input logic [15:0] addr, input logic [15:0] data);
    cur_sel  = sel;
    cur_addr = addr;
    cur_data = data;
  endtask

  task automatic push(input logic [4:0] strb, input logic err, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(vec(strb, err));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Driver tasks: called just after a rising edge while the DUT is idle;
  // return one step into the first cycle after the accepting edge.
  task automatic do_exec(input logic [3:0] strb, input logic [15:0] dst,
                         input logic [15:0] addr, input logic [15:0] data);
    EXEC = 1'b1;
    {STO_IO, STO_RAM, STO_REG, STO_ALU} = strb;
    DST  = dst;
    ADDR = addr;
    DATA = data;
    @(posedge CLK); #1;
    EXEC = 1'b0;
    {STO_IO, STO_RAM, STO_REG, STO_ALU} = 4'b0000;
    DST  = ~dst;
    ADDR = ~addr;
    DATA = ~data;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY === 1'b1 && k < 50) begin
      @(posedge CLK); #1;
      k++;
    end
    check("wait_idle_busy", {63'd0, BUSY}, 64'd0);
  endtask

  // Monitor: every busy cycle must match the next queued vector.
  always @(negedge CLK) begin : monitor
    logic [VW-1:0] act;
    logic [VW-1:0] expv;
    if (!RST && BUSY === 1'b1) begin
      act = {ALU_LD, REG_WE, RAM_WE, IO_WR, DONE, BUSY, ERR, REG_SEL, WADDR, WDATA};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL busy_cycle: got %h expected no busy cycle", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_err++;
          $display("FAIL busy_cycle: got %h expected %h", act, expv);
        end
      end
    end
  end

  // Stimulus
  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {ALU_LD, REG_WE, RAM_WE, IO_WR, DONE, BUSY, ERR, REG_SEL, WADDR, WDATA},
          64'd0);
    check("reset_state", dbg_state, 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Reset in the middle of a RAM wait
    set_cur(3'd1, 16'h1234, 16'h5555);
    push(V_RAM, 1'b0, 2);
    do_exec(4'b0100, 16'h0001, 16'h1234, 16'h5555);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("ram_we_in_wait", RAM_WE, 64'd1);
    RST = 1'b1;
    #1;
    check("rst_abort", {RAM_WE, BUSY, DONE, WDATA, WADDR}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    set_cur(3'd0, 16'h0000, 16'h0000);
    @(posedge CLK); #1;
    check("post_rst_idle", {BUSY, dbg_state}, 64'd0);

    // ALU + REG
    set_cur(3'd5, 16'h0011, 16'hA5A5);
    push(V_ALU, 1'b0, 1);
    push(V_REG, 1'b0, 1);
    push(V_DONE, 1'b0, 1);
    do_exec(4'b0011, 16'h0005, 16'h0011, 16'hA5A5);
    wait_idle();
    check("hold_wdata", {REG_SEL, WADDR, WDATA}, {25'd0, 3'd5, 16'h0011, 16'hA5A5});

    // RAM with ack after 3 wait cycles; EXEC in wait and in FIN is ignored
    set_cur(3'd2, 16'h0040, 16'h1357);
    push(V_RAM, 1'b0, 4);
    push(V_DONE, 1'b0, 1);
    do_exec(4'b0100, 16'h0002, 16'h0040, 16'h1357);
    @(posedge CLK); #1;
    EXEC = 1'b1; STO_ALU = 1'b1; DATA = 16'hBEEF;
    @(posedge CLK); #1;
    EXEC = 1'b0; STO_ALU = 1'b0;
    @(posedge CLK); #1;
    RAM_ACK = 1'b1;
    @(posedge CLK); #1;
    RAM_ACK = 1'b0;
    EXEC = 1'b1; STO_REG = 1'b1; DATA = 16'hDEAD;
    @(posedge CLK); #1;
    EXEC = 1'b0; STO_REG = 1'b0;
    wait_idle();

    // RAM + IO, both acks immediate (acks also high while idle)
    set_cur(3'd7, 16'h0100, 16'hC3C3);
    push(V_RAM, 1'b0, 1);
    push(V_IO, 1'b0, 1);
    push(V_DONE, 1'b0, 1);
    RAM_ACK = 1'b1; IO_ACK = 1'b1;
    do_exec(4'b1100, 16'h0007, 16'h0100, 16'hC3C3);
    @(posedge CLK); #1;
    RAM_ACK = 1'b0;
    @(posedge CLK); #1;
    IO_ACK = 1'b0;
    wait_idle();

    // RAM + IO with a stray IO_ACK throughout the RAM wait
    set_cur(3'd4, 16'h0200, 16'h0F0F);
    push(V_RAM, 1'b0, 2);
    push(V_IO, 1'b0, 1);
    push(V_DONE, 1'b0, 1);
    IO_ACK = 1'b1;
    do_exec(4'b1100, 16'h0004, 16'h0200, 16'h0F0F);
    @(posedge CLK); #1;
    RAM_ACK = 1'b1;
    @(posedge CLK); #1;
    RAM_ACK = 1'b0;
    @(posedge CLK); #1;
    IO_ACK = 1'b0;
    wait_idle();

    // No strobes: DONE straight away, only DST[2:0] latched
    set_cur(3'd0, 16'hFFFF, 16'h0001);
    push(V_DONE, 1'b0, 1);
    do_exec(4'b0000, 16'hFFF8, 16'hFFFF, 16'h0001);
    wait_idle();

    // ALU + IO with IO ack after 2 wait cycles
    set_cur(3'd6, 16'h0300, 16'h7E7E);
    push(V_ALU, 1'b0, 1);
    push(V_IO, 1'b0, 3);
    push(V_DONE, 1'b0, 1);
    do_exec(4'b1001, 16'h0006, 16'h0300, 16'h7E7E);
    repeat (3) @(posedge CLK);
    #1;
    IO_ACK = 1'b1;
    @(posedge CLK); #1;
    IO_ACK = 1'b0;
    wait_idle();

`ifdef MR_STO_TIMEOUT_EN
    // IO ack never arrives: timeout after 4 waiting cycles, ERR sticky
    set_cur(3'd1, 16'h0400, 16'h1111);
    push(V_IO, 1'b0, 4);
    push(V_DONE, 1'b1, 1);
    do_exec(4'b1000, 16'h0001, 16'h0400, 16'h1111);
    wait_idle();
    check("err_sticky", ERR, 64'd1);
    set_cur(3'd0, 16'h0500, 16'h2222);
    push(V_DONE, 1'b0, 1);
    do_exec(4'b0000, 16'h0000, 16'h0500, 16'h2222);
    wait_idle();
    check("err_cleared", ERR, 64'd0);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
